tx_byte_queue: RTL

//  Transmit-side byte buffer that sits directly upstream of the PPM Encoder.

---
 rtl/tx_byte_queue_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/tx_byte_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tx_byte_queue_pkg.sv
// Shared types and defaults for the transmit byte queue.
package tx_byte_queue_pkg;

  localparam int unsigned N_PKT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous register-array FIFO with occupancy count and synchronous clear.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign data_out  = r_mem[r_rd_ptr];

  // Full/empty come from the registered count, so a push while full is
  // dropped even when a pop happens in the same cycle.
  assign w_push_ok = push && !full && !clear;
  assign w_pop_ok  = pop && !empty && !clear;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_byte_queue.sv
// Transmit byte queue: buffers producer bytes and launches them one at a time
// into the PPM Encoder via its start/avail handshake, with an idle gap after
// each completed packet.
module tx_byte_queue
  import tx_byte_queue_pkg::*;
#(
  parameter int unsigned N_PKT  = N_PKT_DEF,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned GAP_CT = 500_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [N_PKT-1:0]       wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [N_PKT-1:0]       enc_data,
  output logic                   enc_start,
  input  logic                   enc_avail,
  output logic                   sent
);

  localparam int unsigned GAP_W = (GAP_CT == 0) ? 1 : $clog2(GAP_CT + 1);

  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_launch;
  logic             w_done;
  logic [N_PKT-1:0] r_enc_data;
  logic             r_enc_start;
  logic             r_sent;

  logic [N_PKT-1:0]       w_fifo_dout;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  logic [$clog2(DEPTH):0] w_fifo_count;

  sync_fifo #(
    .WIDTH (N_PKT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_en),
    .pop      (w_launch),
    .clear    (flush),
    .data_in  (wr_data),
    .data_out (w_fifo_dout),
    .count    (w_fifo_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  assign full      = w_fifo_full;
  assign count     = w_fifo_count;
  assign enc_data  = r_enc_data;
  assign enc_start = r_enc_start;
  assign sent      = r_sent;

  // State register and gap counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_next;
    end
  end

  // Next-state logic for the launch/handshake/gap sequence.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    w_launch     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && enc_avail) begin
          w_launch     = 1'b1;
          w_state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!enc_avail) begin
          w_state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (enc_avail) begin
          w_done       = 1'b1;
          w_state_next = (GAP_CT == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CT)) begin
          w_gap_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_gap_next = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Registered Encoder-side outputs; start is high exactly while in LAUNCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enc_data  <= '0;
      r_enc_start <= 1'b0;
      r_sent      <= 1'b0;
    end else begin
      r_enc_start <= w_launch;
      r_sent      <= w_done;
      if (w_launch) begin
        r_enc_data <= w_fifo_dout;
      end
    end
  end

endmodule
